// File: rtl/ts_bus_sequencer.sv
// ts_bus_sequencer: arbitrates a 4-deep CPU write FIFO and a loader port onto the BDIR/BC/DO sound-block bus.
// Define TS_SEQ_FM_WAIT_EN to add fm_sel tracking and the CE-timed WAIT state after FM data writes.
module ts_bus_sequencer #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 4,
  parameter int FM_WAIT   = 24
) (
  input  logic       CLK,
  input  logic       RESET_s,
  input  logic       CE,
  input  logic       cpu_wr,
  input  logic       cpu_a,
  input  logic [7:0] cpu_di,
  output logic       cpu_full,
  input  logic       ld_req,
  input  logic       ld_a,
  input  logic [7:0] ld_di,
  output logic       ld_ack,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] DO,
  output logic       busy
);

  if (PULSE_LEN < 3 || PULSE_LEN > 15 || GAP_LEN < 3 || GAP_LEN > 15 ||
      FM_WAIT < 1 || FM_WAIT > 255) begin : g_param_check
    $error("ts_bus_sequencer: parameter out of legal range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
`ifdef TS_SEQ_FM_WAIT_EN
    , WAIT = 2'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        bdir_q, bdir_d;
  logic        bc_q, bc_d;
  logic [7:0]  do_q, do_d;
  logic        cur_a_q, cur_a_d;
  logic        cur_ld_q, cur_ld_d;
  logic        lock_q, lock_d;
  logic        lock_ld_q, lock_ld_d;
  logic [8:0]  fifo_q [0:3];
  logic [8:0]  fifo_d [0:3];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
`ifdef TS_SEQ_FM_WAIT_EN
  logic        fm_sel_q, fm_sel_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
`endif

  logic       grant_ld, grant_cpu, push, pop, cmd_write;
  logic [8:0] fifo_head;

  // A held lock pins the grant to its owner; otherwise the loader has priority.
  always_comb begin
    grant_ld  = 1'b0;
    grant_cpu = 1'b0;
    if (state_q == IDLE) begin
      if (lock_q) begin
        if (lock_ld_q) grant_ld  = ld_req;
        else           grant_cpu = (count_q != 3'd0);
      end else if (ld_req) begin
        grant_ld = 1'b1;
      end else begin
        grant_cpu = (count_q != 3'd0);
      end
    end
  end

  assign fifo_head = fifo_q[rd_ptr_q];
  assign pop       = grant_cpu;
  assign push      = cpu_wr && ((count_q != 3'd4) || pop);
  assign cmd_write = (do_q[7:3] == 5'b11111);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bdir_d    = bdir_q;
    bc_d      = bc_q;
    do_d      = do_q;
    cur_a_d   = cur_a_q;
    cur_ld_d  = cur_ld_q;
    lock_d    = lock_q;
    lock_ld_d = lock_ld_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
`ifdef TS_SEQ_FM_WAIT_EN
    fm_sel_d   = fm_sel_q;
    wait_cnt_d = wait_cnt_q;
`endif

    if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
    if (push) begin
      fifo_d[wr_ptr_q] = {cpu_a, cpu_di};
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (grant_ld || grant_cpu) begin
          state_d  = PULSE;
          cnt_d    = 4'(PULSE_LEN - 1);
          bdir_d   = 1'b1;
          cur_ld_d = grant_ld;
          cur_a_d  = grant_ld ? ld_a : fifo_head[8];
          bc_d     = cur_a_d;
          do_d     = grant_ld ? ld_di : fifo_head[7:0];
        end
      end
      PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = GAP;
          cnt_d   = 4'(GAP_LEN - 1);
          bdir_d  = 1'b0;
          bc_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          // Lock and fm_sel bookkeeping happens once the bus cycle has fully completed.
          if (cur_a_q) begin
            if (!cmd_write) begin
              lock_d    = 1'b1;
              lock_ld_d = cur_ld_q;
`ifdef TS_SEQ_FM_WAIT_EN
              fm_sel_d  = (do_q[7:4] != 4'd0);
`endif
            end
          end else begin
            if (lock_q && (lock_ld_q == cur_ld_q)) lock_d = 1'b0;
`ifdef TS_SEQ_FM_WAIT_EN
            if (fm_sel_q) begin
              state_d    = WAIT;
              wait_cnt_d = 8'(FM_WAIT);
            end
`endif
          end
        end
      end
`ifdef TS_SEQ_FM_WAIT_EN
      WAIT: begin
        if (CE) begin
          wait_cnt_d = wait_cnt_q - 8'd1;
          if (wait_cnt_q == 8'd1) state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET_s) begin
    if (RESET_s) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bdir_q    <= 1'b0;
      bc_q      <= 1'b0;
      do_q      <= '0;
      cur_a_q   <= 1'b0;
      cur_ld_q  <= 1'b0;
      lock_q    <= 1'b0;
      lock_ld_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
`ifdef TS_SEQ_FM_WAIT_EN
      fm_sel_q   <= 1'b0;
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bdir_q    <= bdir_d;
      bc_q      <= bc_d;
      do_q      <= do_d;
      cur_a_q   <= cur_a_d;
      cur_ld_q  <= cur_ld_d;
      lock_q    <= lock_d;
      lock_ld_q <= lock_ld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      fifo_q    <= fifo_d;
`ifdef TS_SEQ_FM_WAIT_EN
      fm_sel_q   <= fm_sel_d;
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign BDIR     = bdir_q;
  assign BC       = bc_q;
  assign DO       = do_q;
  assign cpu_full = (count_q == 3'd4);
  assign busy     = (state_q != IDLE) || (count_q != 3'd0);
  assign ld_ack   = grant_ld && !RESET_s;

endmodule

// File: doc/ts_bus_sequencer.md
TS_BUS_SEQUENCER -- requirements
Module: ts_bus_sequencer

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 4: CLK cycles BDIR is held high per bus cycle (legal range 3..15).
REQ-002 SHALL have parameter GAP_LEN, default 4: CLK cycles BDIR is held low after each bus cycle (legal range 3..15).
REQ-003 SHALL have parameter FM_WAIT, default 24: CE pulses of busy wait after an FM data write (legal range 1..255).
REQ-004 SHALL have ports, in this order:
- CLK  in  1  clock.
- RESET_s  in  1  reset, asynchronous, active-high.
- CE  in  1  YM master clock enable.
- cpu_wr  in  1  CPU write strobe, one cycle.
- cpu_a  in  1  port select: 1=address/command, 0=data.
- cpu_di  in  8  CPU write data.
- cpu_full  out  1  CPU FIFO full.
- ld_req  in  1  loader request, held until acked.
- ld_a  in  1  loader port select, same encoding as cpu_a.
- ld_di  in  8  loader data.
- ld_ack  out  1  one-cycle pulse when the loader request is accepted.
- BDIR  out  1  to sound block.
- BC  out  1  to sound block.
- DO  out  8  to sound block.
- busy  out  1  sequencer not idle, or FIFO not empty.

Function
REQ-005 SHALL buffer CPU writes in a 4-entry FIFO of {a, di}; cpu_wr while full SHALL be dropped; cpu_full SHALL be 1 exactly when 4 entries are held.
REQ-006 cpu_wr and a pop in the same cycle while full SHALL accept the write.
REQ-007 SHALL use FSM states IDLE, PULSE, GAP, WAIT.
REQ-008 IDLE->PULSE SHALL occur on the first cycle a granted request exists. In PULSE: BDIR=1, BC=a, DO=data, for PULSE_LEN cycles.
REQ-009 PULSE->GAP: BDIR=0, BC=0, DO held, for GAP_LEN cycles.
REQ-010 GAP->WAIT if REQ-014 applies, else GAP->IDLE.
REQ-011 Arbitration: the loader SHALL win when no lock is held; the CPU FIFO is served otherwise. The grant SHALL be sampled only in IDLE.
REQ-012 Lock: an address write (a=1) with di[7:3]!=5'b11111 SHALL lock the grant to that requester until its next data write (a=0) completes GAP. Chip-select commands (di[7:3]=5'b11111) SHALL NOT lock.
REQ-013 ld_ack SHALL pulse in the IDLE->PULSE cycle for a loader transaction. The FIFO pop SHALL occur in the same cycle for a CPU transaction.
REQ-014 SHALL track fm_sel: set by a non-command address write with di[7:4]!=0, cleared by one with di[7:4]==0. A data write completed with fm_sel=1 SHALL enter WAIT for FM_WAIT CE pulses, then go to IDLE.
REQ-015 CE SHALL affect only the WAIT counter.
REQ-016 Minimum transaction length SHALL be PULSE_LEN+GAP_LEN cycles; back-to-back transactions SHALL have no extra IDLE cycle beyond one.
REQ-017 Loader and CPU both pending in IDLE, with the CPU holding the lock: the CPU SHALL be served and ld_ack withheld.

Reset
REQ-018 RESET_s asserted SHALL immediately force: state IDLE; BDIR=0, BC=0, DO=0; ld_ack=0; FIFO empty (cpu_full=0); lock released; fm_sel=0; counters 0; busy=0.
REQ-019 Reset mid-PULSE SHALL abort the cycle; the aborted entry SHALL NOT be retried.

Configuration
REQ-020 Macro TS_SEQ_FM_WAIT_EN defined: REQ-014 WAIT behaviour and fm_sel SHALL be present.
REQ-021 Macro TS_SEQ_FM_WAIT_EN undefined: the WAIT state and FM_WAIT counter SHALL be absent; GAP SHALL always go to IDLE.

Verification
REQ-022 CPU write a=1 di=0x07, then a=0 di=0x38 -> two PULSE windows of 4 cycles each (BC=1 DO=07, then BC=0 DO=38), 4-cycle gaps, no WAIT.
REQ-023 5 cpu_wr back-to-back with no service -> cpu_full=1 after the 4th, 5th write dropped, exactly 4 bus cycles emitted.
REQ-024 CPU address write 0x28 pending, then ld_req -> CPU data write completes before ld_ack pulses.
REQ-025 Address 0x28, data 0xF0 with FM wait enabled, CE every 4 CLK -> WAIT lasts 24 CE pulses (96 CLK) before the next PULSE; without macro, no WAIT.
REQ-026 CPU write 0xFE to address port -> single PULSE, no lock; pending ld_req acked next.
REQ-027 RESET_s at cycle 2 of PULSE -> BDIR=0 same cycle, FIFO empty, busy=0, no retry after release.
